// File: rtl/lib_arbiter_pkg.sv
// rtl/lib_arbiter_pkg.sv - shared AER word layout and output-stage state encoding
package lib_arbiter_pkg;

  localparam int WIDTH = 24;

  typedef struct packed {
    logic [5:0]  x_add;
    logic [5:0]  y_add;
    logic [10:0] timestamp;
    logic        polarity;
  } aer_word_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    VALID = 1'b1
  } out_state_e;

endpackage

// File: rtl/aer_event_scheduler_if.sv
// rtl/aer_event_scheduler_if.sv - event input, hold throttle and readout link of the scheduler
interface aer_event_scheduler_if
  import lib_arbiter_pkg::*;
#(
  parameter int DATA_W = WIDTH
);

  logic              evt_valid;
  logic [DATA_W-1:0] evt_data;
  logic              hold;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output evt_valid, evt_data, out_ready,
    input  hold, out_valid, out_data
  );

  modport slave (
    input  evt_valid, evt_data, out_ready,
    output hold, out_valid, out_data
  );

endinterface

// File: rtl/aer_sync_fifo.sv
// rtl/aer_sync_fifo.sv - synchronous FIFO with separate occupancy count and flush
module aer_sync_fifo
  import lib_arbiter_pkg::*;
#(
  parameter int DATA_W = WIDTH,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i  && !flush_i && (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/aer_event_scheduler.sv
// rtl/aer_event_scheduler.sv - buffers hierarchy AER events and streams them to readout with throttle and drop stats
module aer_event_scheduler
  import lib_arbiter_pkg::*;
#(
  parameter int DATA_W       = WIDTH,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2,
  parameter int DROP_W       = 16,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  clr_stat_i,
  aer_event_scheduler_if.slave  bus,
  output logic [CW-1:0]         fifo_count_o,
  output logic                  overflow_o,
  output logic [DROP_W-1:0]     drop_cnt_o
);

  localparam logic [0:0] S_EMPTY = EMPTY;
  localparam logic [0:0] S_VALID = VALID;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     free_slots;
  logic              full, fifo_empty, push, pop, drop, handshake;

  aer_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .flush_i (flush_i),
    .push_i  (push),
    .wdata_i (bus.evt_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  // Fullness uses the registered count, so a same-cycle pop never frees a slot for the incoming event.
  assign full       = (fifo_count == CW'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign handshake  = (state_q == S_VALID) && bus.out_ready;
  assign push       = bus.evt_valid && !full && !flush_i;
  assign drop       = bus.evt_valid &&  full && !flush_i;
  assign pop        = !fifo_empty && !flush_i && ((state_q == S_EMPTY) || handshake);

  assign free_slots = CW'(DEPTH) - fifo_count;
  assign bus.hold   = (free_slots <= CW'(AFULL_MARGIN));

  assign bus.out_valid = (state_q == S_VALID);
  assign bus.out_data  = data_q;
  assign fifo_count_o  = fifo_count;
  assign overflow_o    = ovf_q;
  assign drop_cnt_o    = drop_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else if (pop) begin
      state_d = S_VALID;
      data_d  = fifo_rdata;
    end else if (handshake) begin
      state_d = S_EMPTY;
    end
  end

  // A clear that coincides with a drop records that drop rather than losing it.
  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clr_stat_i) begin
      ovf_d  = drop;
      drop_d = DROP_W'(drop);
    end else if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_aer_event_scheduler.sv
// tb/tb_aer_event_scheduler.sv - self-checking bench for aer_event_scheduler
module tb_aer_event_scheduler;
  import lib_arbiter_pkg::*;

  localparam int W = WIDTH;
  localparam int DEPTH = 16;
  localparam int AFULL = 2;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic flush_i = 1'b0;
  logic clr_stat_i = 1'b0;
  logic [CW-1:0] fifo_count_o;
  logic overflow_o;
  logic [15:0] drop_cnt_o;

  aer_event_scheduler_if #(.DATA_W(W)) bus ();

  aer_event_scheduler #(.DATA_W(W), .DEPTH(DEPTH), .AFULL_MARGIN(AFULL), .DROP_W(16)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .flush_i      (flush_i),
    .clr_stat_i   (clr_stat_i),
    .bus          (bus),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO contents as a queue plus the word on the link.
  logic [W-1:0] mq[$];
  logic [W-1:0] acc[$];
  logic [W-1:0] rx[$];
  bit m_v = 0;
  logic [W-1:0] m_d = '0;
  int m_drop = 0;
  bit m_ovf = 0;

  typedef struct {
    bit evt; logic [W-1:0] data; bit rdy; bit fl; bit clr;
    bit e_valid; logic [W-1:0] e_data; int e_count; bit e_hold; int e_drop;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit evt, input logic [W-1:0] d, input bit rdy, input bit fl, input bit clr);
    bus.evt_valid = evt;
    bus.evt_data  = d;
    bus.out_ready = rdy;
    flush_i       = fl;
    clr_stat_i    = clr;
  endtask

  task automatic model_step();
    bit dropped, hs;
    dropped = 0;
    if (reset_i) begin
      mq.delete(); m_v = 0; m_d = '0; m_drop = 0; m_ovf = 0;
    end else begin
      if (flush_i) begin
        mq.delete(); m_v = 0;
      end else begin
        hs = m_v && bus.out_ready;
        if (bus.evt_valid && mq.size() == DEPTH) dropped = 1;
        if ((!m_v || hs) && mq.size() > 0) begin
          m_d = mq.pop_front(); m_v = 1;
        end else if (hs) begin
          m_v = 0;
        end
        if (bus.evt_valid && !dropped) begin
          mq.push_back(bus.evt_data); acc.push_back(bus.evt_data);
        end
      end
      if (clr_stat_i) begin
        m_drop = dropped ? 1 : 0; m_ovf = dropped;
      end else if (dropped) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  task automatic cycle();
    if (bus.out_valid && bus.out_ready && !reset_i && !flush_i) rx.push_back(bus.out_data);
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_v));
    if (m_v) chk("out_data", 32'(bus.out_data), 32'(m_d));
    chk("fifo_count", 32'(fifo_count_o), 32'(mq.size()));
    chk("hold", 32'(bus.hold), 32'((DEPTH - mq.size()) <= AFULL));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_data"}, 32'(bus.out_data), 0);
    chk({tag, "_count"}, 32'(fifo_count_o), 0);
    chk({tag, "_hold"}, 32'(bus.hold), 0);
    chk({tag, "_ovf"}, 32'(overflow_o), 0);
    chk({tag, "_drop"}, 32'(drop_cnt_o), 0);
  endtask

  initial begin
    bit stall;
    logic [W-1:0] sd;
    int sent, guard;

    drive(0, '0, 0, 0, 0);
    reset_i = 1;
    repeat (3) cycle();
    chk_all_zero("reset");
    reset_i = 0;

    // Single event latency, then five buffered events flushed alongside a new write.
    tbl[0] = '{1, 24'h0A5, 1, 0, 0,  0, 24'h0,   1, 0, 0};
    tbl[1] = '{0, 24'h0,   1, 0, 0,  1, 24'h0A5, 0, 0, 0};
    tbl[2] = '{0, 24'h0,   1, 0, 0,  0, 24'h0,   0, 0, 0};
    tbl[3] = '{1, 24'h1,   0, 0, 0,  0, 24'h0,   1, 0, 0};
    tbl[4] = '{1, 24'h2,   0, 0, 0,  1, 24'h1,   1, 0, 0};
    tbl[5] = '{1, 24'h3,   0, 0, 0,  1, 24'h1,   2, 0, 0};
    tbl[6] = '{1, 24'h4,   0, 0, 0,  1, 24'h1,   3, 0, 0};
    tbl[7] = '{1, 24'h5,   0, 0, 0,  1, 24'h1,   4, 0, 0};
    tbl[8] = '{1, 24'h6,   0, 1, 0,  0, 24'h0,   0, 0, 0};
    tbl[9] = '{0, 24'h0,   0, 0, 0,  0, 24'h0,   0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].evt, tbl[i].data, tbl[i].rdy, tbl[i].fl, tbl[i].clr);
      cycle();
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
      chk($sformatf("vec%0d_count", i), 32'(fifo_count_o), 32'(tbl[i].e_count));
      chk($sformatf("vec%0d_hold", i), 32'(bus.hold), 32'(tbl[i].e_hold));
      chk($sformatf("vec%0d_drop", i), 32'(drop_cnt_o), 32'(tbl[i].e_drop));
    end

    // Fill with consumer stalled: 17 fit, the 18th drops.
    rx.delete();
    for (int i = 1; i <= 18; i++) begin
      drive(1, 24'(i), 0, 0, 0);
      cycle();
      if (i == 14) chk("fill14_hold", 32'(bus.hold), 0);
      if (i == 15) begin
        chk("fill15_count", 32'(fifo_count_o), 14);
        chk("fill15_hold", 32'(bus.hold), 1);
      end
      if (i == 16) chk("fill16_count", 32'(fifo_count_o), 15);
      if (i == 17) chk("fill17_count", 32'(fifo_count_o), 16);
    end
    chk("fill18_drop", 32'(drop_cnt_o), 1);
    chk("fill18_ovf", 32'(overflow_o), 1);
    drive(1, 24'h99, 1, 0, 0);
    cycle();
    chk("fullpop_count", 32'(fifo_count_o), DEPTH - 1);
    chk("fullpop_drop", 32'(drop_cnt_o), 2);
    chk("fullpop_data", 32'(bus.out_data), 2);
    drive(0, '0, 1, 0, 0);
    repeat (20) cycle();
    chk("drain_n", rx.size(), 17);
    for (int i = 0; i < 17 && i < rx.size(); i++) chk($sformatf("drain_%0d", i), 32'(rx[i]), 32'(i + 1));

    // Random backpressure, 100 accepted events.
    rx.delete(); acc.delete();
    sent = 0; guard = 0;
    while (sent < 100 && guard < 2000) begin
      drive(($urandom_range(0, 9) < 7) && !bus.hold, 24'($urandom), $urandom_range(0, 1), 0, 0);
      if (bus.evt_valid) sent++;
      stall = bus.out_valid && !bus.out_ready;
      sd = bus.out_data;
      cycle();
      if (stall) begin
        chk("bp_hold_valid", 32'(bus.out_valid), 1);
        chk("bp_stable", 32'(bus.out_data), 32'(sd));
      end
      guard++;
    end
    chk("bp_sent", sent, 100);
    drive(0, '0, 1, 0, 0);
    repeat (40) cycle();
    chk("bp_rx_n", rx.size(), acc.size());
    for (int i = 0; i < acc.size() && i < rx.size(); i++) chk($sformatf("bp_order_%0d", i), 32'(rx[i]), 32'(acc[i]));

    // Reset in the middle of a stream.
    for (int i = 0; i < 6; i++) begin
      drive(1, 24'(16'hA00 + i), i[0], 0, 0);
      cycle();
    end
    reset_i = 1;
    cycle();
    chk_all_zero("midreset");
    reset_i = 0;

    // Drop counter saturation and clear behaviour.
    for (int i = 0; i < 17; i++) begin
      drive(1, 24'(i), 0, 0, 0);
      cycle();
    end
    drive(1, 24'h5A5, 0, 0, 0);
    for (int i = 0; i < 65539; i++) cycle();
    chk("sat_drop", 32'(drop_cnt_o), 32'h0000FFFF);
    chk("sat_ovf", 32'(overflow_o), 1);
    drive(0, '0, 0, 0, 1);
    cycle();
    chk("clr_drop", 32'(drop_cnt_o), 0);
    chk("clr_ovf", 32'(overflow_o), 0);
    drive(1, 24'h77, 0, 0, 1);
    cycle();
    chk("clrdrop_drop", 32'(drop_cnt_o), 1);
    chk("clrdrop_ovf", 32'(overflow_o), 1);
    drive(0, '0, 0, 1, 0);
    cycle();
    chk("flush_keeps_drop", 32'(drop_cnt_o), 1);
    chk("flush_count", 32'(fifo_count_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
